rf_sum_controller: RTL and testbench
====================================

Name: rf_sum_controller

Overview:
- Moore FSM that sequences the register-file dedicated-processor datapath (4-entry register file, adder, less-than comparator, output register) to compute sum = 1+2+...+N.
- N is captured at start; the controller handshakes with a host through start/busy/done and supports abort.
- It drives only control signals. All data storage and arithmetic stay in the datapath, which compares its rdata1 < limit_q and returns lt.

Parameters:
- DATA_W, 8, datapath word width; also width of limit, imm and limit_q.
- ADDR_W, 2, register-file address width. R0 is hardwired zero in the datapath.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- limit  in  DATA_W  N, captured into limit_q when start is accepted
- abort  in  1  return to IDLE next edge, no done pulse
- lt  in  1  datapath comparator result (rdata1 < limit_q), combinational from datapath
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in OUT
- rf_we  out  1  register-file write enable
- waddr  out  ADDR_W  write address
- raddr1  out  ADDR_W  read port 1 address (ALU operand A, comparator input)
- raddr2  out  ADDR_W  read port 2 address (ALU operand B)
- wdata_sel  out  1  0 = ALU sum (rdata1+rdata2), 1 = imm
- imm  out  DATA_W  immediate write data
- out_en  out  1  load datapath output register from rdata1
- limit_q  out  DATA_W  latched N, fed to datapath comparator

Behaviour:
- Reset: at any rising edge with rst=1:
  - state=IDLE and limit_q=0.
  - All outputs 0 (rf_we, out_en, done, busy, wdata_sel, imm, all addresses).
  - rst overrides abort and start. Reset mid-operation discards progress; register-file contents are not the controller's concern.
- Outputs are pure functions of state (Moore). Defaults are all 0, and each state overrides only the outputs listed below.
- States and per-state outputs:
  - IDLE: outputs all 0. If start=1, then limit_q<=limit and next=INIT_I; else stay.
  - INIT_I: rf_we=1, waddr=R_I, wdata_sel=1, imm=0. Next INIT_S.
  - INIT_S: rf_we=1, waddr=R_S, wdata_sel=1, imm=0. Next INIT_C.
  - INIT_C: rf_we=1, waddr=R_C, wdata_sel=1, imm=1. Next CMP.
  - CMP: raddr1=R_I, no write. If lt=1 go to ADD_I, else go to OUT.
  - ADD_I: raddr1=R_I, raddr2=R_C, rf_we=1, waddr=R_I, wdata_sel=0 (i <= i+1). Next ADD_S.
  - ADD_S: raddr1=R_S, raddr2=R_I, rf_we=1, waddr=R_S, wdata_sel=0 (sum <= sum+i). Next CMP.
  - OUT: raddr1=R_S, out_en=1, done=1. Next IDLE.
- busy=1 in all states except IDLE, including OUT.
- Latency: start accepted at edge k puts INIT_I in cycle k+1. done is high in cycle k+3N+5, and busy is high for exactly 3N+5 cycles.
- start is ignored while busy, and limit changes while busy are ignored (limit_q held).
- start in the same cycle OUT returns to IDLE is not accepted. A new start is accepted the cycle after done at the earliest (in IDLE).
- abort=1 in any non-IDLE state:
  - next=IDLE; done and out_en are not asserted that cycle; limit_q is held.
  - abort in OUT: done still pulses (state output), next=IDLE regardless.
- Arithmetic wraps modulo 2^DATA_W in the datapath. The controller adds no overflow handling.
- Termination is guaranteed because i increments until i == N (i < N is false). N=0 takes the exit path on the first CMP.
- Illegal or unreachable state encodings go to IDLE on the next edge with default outputs.

Decomposition:
- Package rf_sum_pkg:
  - state_t enum {IDLE, INIT_I, INIT_S, INIT_C, CMP, ADD_I, ADD_S, OUT}.
  - Register-address constants R_ZERO=0, R_I=1, R_S=2, R_C=3.
  - wdata_sel encodings WSEL_ALU=0, WSEL_IMM=1.
- Single module, no sub-module. The top-level wires it to the existing register-file datapath.

Test Plan:
- limit=10, start one cycle, then idle → done high exactly in cycle 35 after start accept, datapath output = 55, busy high 35 cycles.
- limit=0 → done in cycle 5 with output 0, ADD_I/ADD_S never entered (rf_we on R_I only in INIT_I).
- limit=23, DATA_W=8 → output 276 mod 256 = 20, done at cycle 74.
- Pulse start again at cycles 3 and 20 of a limit=10 run with limit=5 on the bus → ignored, result still 55, limit_q stays 10.
- limit=10 run, assert abort in ADD_S of the 4th iteration → IDLE next edge, no done or out_en. A following start with limit=4 yields 10 after 17 cycles.
- limit=10 run, assert rst in cycle 12 → next cycle all outputs 0, limit_q=0, IDLE. A subsequent start with limit=3 gives 6 at cycle 14.

Source files
------------

// File: rtl/rf_sum_pkg.sv
// Shared types and constants for the register-file summation controller.
package rf_sum_pkg;

   // Controller states, in sequencing order.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT_I = 3'd1,
      INIT_S = 3'd2,
      INIT_C = 3'd3,
      CMP    = 3'd4,
      ADD_I  = 3'd5,
      ADD_S  = 3'd6,
      OUT    = 3'd7
   } state_t;

   // Register-file roles: R0 is hardwired zero in the datapath.
   localparam int R_ZERO = 0;
   localparam int R_I    = 1;   // loop counter i
   localparam int R_S    = 2;   // running sum
   localparam int R_C    = 3;   // constant one

   // Write-data source select.
   localparam logic WSEL_ALU = 1'b0;
   localparam logic WSEL_IMM = 1'b1;

endpackage : rf_sum_pkg

// File: rtl/rf_sum_controller.sv
// Moore controller sequencing the register-file datapath to compute 1+2+...+N.
// Outputs are registered from the next state, so each output is a pure
// function of the current state while still coming straight from flops.
module rf_sum_controller
   import rf_sum_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] limit,
   input  logic              abort,
   input  logic              lt,
   output logic              busy,
   output logic              done,
   output logic              rf_we,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W-1:0] raddr1,
   output logic [ADDR_W-1:0] raddr2,
   output logic              wdata_sel,
   output logic [DATA_W-1:0] imm,
   output logic              out_en,
   output logic [DATA_W-1:0] limit_q
);

   state_t state_r;
   state_t next_s;

   // Next-state selection; abort from any active state wins over sequencing.
   always_comb begin
      next_s = IDLE;
      if ((state_r != IDLE) && abort) begin
         next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  next_s = INIT_I;
               end else begin
                  next_s = IDLE;
               end
            end
            INIT_I: next_s = INIT_S;
            INIT_S: next_s = INIT_C;
            INIT_C: next_s = CMP;
            CMP: begin
               if (lt) begin
                  next_s = ADD_I;
               end else begin
                  next_s = OUT;
               end
            end
            ADD_I:   next_s = ADD_S;
            ADD_S:   next_s = CMP;
            OUT:     next_s = IDLE;
            default: next_s = IDLE;
         endcase
      end
   end

   // State, latched limit and the registered per-state control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         limit_q   <= DATA_W'(0);
         busy      <= 1'b0;
         done      <= 1'b0;
         rf_we     <= 1'b0;
         waddr     <= ADDR_W'(0);
         raddr1    <= ADDR_W'(0);
         raddr2    <= ADDR_W'(0);
         wdata_sel <= WSEL_ALU;
         imm       <= DATA_W'(0);
         out_en    <= 1'b0;
      end else begin
         state_r <= next_s;
         // N is only captured on the accepting edge; held otherwise.
         if ((state_r == IDLE) && start) begin
            limit_q <= limit;
         end else begin
            limit_q <= limit_q;
         end

         busy      <= (next_s != IDLE);
         done      <= 1'b0;
         rf_we     <= 1'b0;
         waddr     <= ADDR_W'(0);
         raddr1    <= ADDR_W'(0);
         raddr2    <= ADDR_W'(0);
         wdata_sel <= WSEL_ALU;
         imm       <= DATA_W'(0);
         out_en    <= 1'b0;

         case (next_s)
            IDLE: begin
               busy <= 1'b0;
            end
            INIT_I: begin
               rf_we     <= 1'b1;
               waddr     <= ADDR_W'(R_I);
               wdata_sel <= WSEL_IMM;
               imm       <= DATA_W'(0);
            end
            INIT_S: begin
               rf_we     <= 1'b1;
               waddr     <= ADDR_W'(R_S);
               wdata_sel <= WSEL_IMM;
               imm       <= DATA_W'(0);
            end
            INIT_C: begin
               rf_we     <= 1'b1;
               waddr     <= ADDR_W'(R_C);
               wdata_sel <= WSEL_IMM;
               imm       <= DATA_W'(1);
            end
            CMP: begin
               raddr1 <= ADDR_W'(R_I);
            end
            ADD_I: begin
               raddr1    <= ADDR_W'(R_I);
               raddr2    <= ADDR_W'(R_C);
               rf_we     <= 1'b1;
               waddr     <= ADDR_W'(R_I);
               wdata_sel <= WSEL_ALU;
            end
            ADD_S: begin
               raddr1    <= ADDR_W'(R_S);
               raddr2    <= ADDR_W'(R_I);
               rf_we     <= 1'b1;
               waddr     <= ADDR_W'(R_S);
               wdata_sel <= WSEL_ALU;
            end
            OUT: begin
               raddr1 <= ADDR_W'(R_S);
               out_en <= 1'b1;
               done   <= 1'b1;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule : rf_sum_controller

// File: tb/tb_rf_sum_controller.sv
// Directed bench: controller plus a behavioural register-file datapath.
module tb_rf_sum_controller;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [DATA_W-1:0] limit;
   logic              abort;
   logic              lt;
   logic              busy;
   logic              done;
   logic              rf_we;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic              wdata_sel;
   logic [DATA_W-1:0] imm;
   logic              out_en;
   logic [DATA_W-1:0] limit_q;

   int n_checks = 0;
   int n_fail   = 0;

   rf_sum_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .limit(limit), .abort(abort),
      .lt(lt), .busy(busy), .done(done), .rf_we(rf_we), .waddr(waddr),
      .raddr1(raddr1), .raddr2(raddr2), .wdata_sel(wdata_sel), .imm(imm),
      .out_en(out_en), .limit_q(limit_q)
   );

   always #5 clk = ~clk;

   // Datapath: 4-entry register file (R0 = 0), adder, comparator, output reg.
   logic [DATA_W-1:0] rf [0:3] = '{default: '0};
   logic [DATA_W-1:0] dp_out = '0;
   logic [DATA_W-1:0] wdata;

   assign wdata = wdata_sel ? imm : (rf[raddr1] + rf[raddr2]);
   assign lt    = (rf[raddr1] < limit_q);

   always @(posedge clk) begin
      if (rf_we && (waddr != 2'd0)) rf[waddr] <= wdata;
      if (rst) dp_out <= '0;
      else if (out_en) dp_out <= rf[raddr1];
   end

   // Accept a start from IDLE; returns at the negedge of cycle 1 (INIT_I).
   task automatic kick(input logic [DATA_W-1:0] lim);
      limit = lim;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Walk cycles from cycle 1 until done; reports done cycle, busy count, R_I writes.
   task automatic wait_done(input int budget, output int dc, output int bc, output int iw);
      int c;
      c  = 1;
      dc = -1;
      bc = 0;
      iw = 0;
      while (c <= budget) begin
         if (busy) bc++;
         if (rf_we && waddr == 2'd1) iw++;
         if (done) begin
            dc = c;
            break;
         end
         @(negedge clk);
         c++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; limit = 8'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, rf_we, waddr, raddr1, raddr2, wdata_sel, imm, out_en, limit_q} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b we=%b wa=%0d r1=%0d r2=%0d sel=%b imm=%0d oe=%b lq=%0d, want all 0",
                  busy, done, rf_we, waddr, raddr1, raddr2, wdata_sel, imm, out_en, limit_q);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_start: busy=%b want 0", busy);
      end
   endtask

   task automatic test_sum10();
      int dc, bc, iw;
      kick(8'd10);
      n_checks++;
      if (busy !== 1'b1 || limit_q !== 8'd10 || rf_we !== 1'b1 || waddr !== 2'd1 || imm !== 8'd0) begin
         n_fail++;
         $display("FAIL sum10_init_i: busy=%b lq=%0d we=%b wa=%0d imm=%0d want 1/10/1/1/0",
                  busy, limit_q, rf_we, waddr, imm);
      end
      wait_done(200, dc, bc, iw);
      n_checks++;
      if (dc !== 35 || bc !== 35) begin
         n_fail++;
         $display("FAIL sum10_timing: done_cycle=%0d busy_cycles=%0d want 35/35", dc, bc);
      end
      n_checks++;
      if (out_en !== 1'b1 || raddr1 !== 2'd2) begin
         n_fail++;
         $display("FAIL sum10_out_state: out_en=%b raddr1=%0d want 1/2", out_en, raddr1);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dp_out !== 8'd55) begin
         n_fail++;
         $display("FAIL sum10_result: done=%b busy=%b out=%0d want 0/0/55", done, busy, dp_out);
      end
   endtask

   task automatic test_zero();
      int dc, bc, iw;
      kick(8'd0);
      wait_done(200, dc, bc, iw);
      n_checks++;
      if (dc !== 5 || iw !== 1) begin
         n_fail++;
         $display("FAIL zero_timing: done_cycle=%0d ri_writes=%0d want 5/1", dc, iw);
      end
      @(negedge clk);
      n_checks++;
      if (dp_out !== 8'd0) begin
         n_fail++;
         $display("FAIL zero_result: out=%0d want 0", dp_out);
      end
   endtask

   task automatic test_wrap();
      int dc, bc, iw;
      kick(8'd23);
      wait_done(300, dc, bc, iw);
      n_checks++;
      if (dc !== 74 || bc !== 74) begin
         n_fail++;
         $display("FAIL wrap_timing: done_cycle=%0d busy_cycles=%0d want 74/74", dc, bc);
      end
      @(negedge clk);
      n_checks++;
      if (dp_out !== 8'd20) begin
         n_fail++;
         $display("FAIL wrap_result: out=%0d want 20", dp_out);
      end
   endtask

   task automatic test_ignore_start();
      int c, dc, bad_lq;
      kick(8'd10);
      c = 1; dc = -1; bad_lq = 0;
      limit = 8'd5;
      while (c <= 200) begin
         if (limit_q !== 8'd10) bad_lq++;
         if (done) begin
            dc = c;
            break;
         end
         start = (c == 3 || c == 20);
         @(negedge clk);
         c++;
      end
      start = 1'b0;
      n_checks++;
      if (dc !== 35 || bad_lq !== 0) begin
         n_fail++;
         $display("FAIL ignore_start_timing: done_cycle=%0d bad_limit_q_cycles=%0d want 35/0", dc, bad_lq);
      end
      @(negedge clk);
      n_checks++;
      if (dp_out !== 8'd55 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_start_result: out=%0d busy=%b want 55/0", dp_out, busy);
      end
   endtask

   task automatic test_abort();
      int dc, bc, iw, seen_done;
      kick(8'd10);
      seen_done = 0;
      for (int c = 1; c < 15; c++) begin
         if (done || out_en) seen_done++;
         @(negedge clk);
      end
      n_checks++;
      if (rf_we !== 1'b1 || waddr !== 2'd2 || raddr2 !== 2'd1 || seen_done !== 0) begin
         n_fail++;
         $display("FAIL abort_in_add_s: we=%b wa=%0d r2=%0d early_done=%0d want 1/2/1/0",
                  rf_we, waddr, raddr2, seen_done);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_en !== 1'b0 || limit_q !== 8'd10 || dp_out !== 8'd55) begin
         n_fail++;
         $display("FAIL abort_idle: busy=%b done=%b oe=%b lq=%0d out=%0d want 0/0/0/10/55",
                  busy, done, out_en, limit_q, dp_out);
      end
      kick(8'd4);
      wait_done(200, dc, bc, iw);
      n_checks++;
      if (dc !== 17) begin
         n_fail++;
         $display("FAIL abort_rerun_timing: done_cycle=%0d want 17", dc);
      end
      @(negedge clk);
      n_checks++;
      if (dp_out !== 8'd10) begin
         n_fail++;
         $display("FAIL abort_rerun_result: out=%0d want 10", dp_out);
      end
   endtask

   task automatic test_reset_mid();
      int dc, bc, iw;
      kick(8'd10);
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({busy, done, rf_we, waddr, raddr1, raddr2, wdata_sel, imm, out_en, limit_q} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: busy=%b done=%b we=%b wa=%0d r1=%0d r2=%0d sel=%b imm=%0d oe=%b lq=%0d, want all 0",
                  busy, done, rf_we, waddr, raddr1, raddr2, wdata_sel, imm, out_en, limit_q);
      end
      kick(8'd3);
      wait_done(200, dc, bc, iw);
      n_checks++;
      if (dc !== 14 || bc !== 14) begin
         n_fail++;
         $display("FAIL reset_mid_rerun_timing: done_cycle=%0d busy_cycles=%0d want 14/14", dc, bc);
      end
      @(negedge clk);
      n_checks++;
      if (dp_out !== 8'd6) begin
         n_fail++;
         $display("FAIL reset_mid_rerun_result: out=%0d want 6", dp_out);
      end
   endtask

   initial begin
      test_reset();
      test_sum10();
      test_zero();
      test_wrap();
      test_ignore_start();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rf_sum_controller
